// File: rtl/timing_pkg.sv
// Shared constants for the seconds/minutes timing generator and its counters.
package timing_pkg;

  localparam int DEFAULT_CLOCKS_PER_SECOND  = 256;
  localparam int DEFAULT_SECONDS_PER_MINUTE = 60;

  localparam int MIN_MODULUS            = 2;
  localparam int MAX_CLOCKS_PER_SECOND  = 2 ** 24;
  localparam int MAX_SECONDS_PER_MINUTE = 255;

endpackage

// File: rtl/timing_generator_if.sv
// Pulse bundle produced by timing_generator: the generator drives, consumers listen.
interface timing_generator_if;

  logic one_second;
  logic one_minute;

  modport master (output one_second, output one_minute);
  modport slave  (input  one_second, input  one_minute);

endinterface

// File: rtl/mod_counter.sv
// Modulo-N counter with enable; terminal flags the enabled cycle that wraps to 0.
module mod_counter
  import timing_pkg::*;
#(
    parameter int MODULUS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    output logic [$clog2(MODULUS)-1:0] count,
    output logic                       terminal
);

    localparam int W = $clog2(MODULUS);
    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    if (MODULUS < MIN_MODULUS) begin : g_bad_modulus
        $error("mod_counter: MODULUS must be at least 2");
    end

    assign terminal = enable && (count == LAST);

    // NOTE: non-blocking updates so every flop samples pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (terminal) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/timing_generator.sv
// Derives registered one-cycle one_second / one_minute pulses from clk via two chained modulo counters.
module timing_generator
  import timing_pkg::*;
#(
    parameter int CLOCKS_PER_SECOND  = DEFAULT_CLOCKS_PER_SECOND,
    parameter int SECONDS_PER_MINUTE = DEFAULT_SECONDS_PER_MINUTE
) (
    input  logic clk,
    input  logic reset,
    output logic one_second,
    output logic one_minute
);

    localparam int PRESC_W = $clog2(CLOCKS_PER_SECOND);
    localparam int SEC_W   = $clog2(SECONDS_PER_MINUTE);

    if (CLOCKS_PER_SECOND < MIN_MODULUS || CLOCKS_PER_SECOND > MAX_CLOCKS_PER_SECOND) begin : g_bad_cps
        $error("timing_generator: CLOCKS_PER_SECOND must be in 2..2**24");
    end
    if (SECONDS_PER_MINUTE < MIN_MODULUS || SECONDS_PER_MINUTE > MAX_SECONDS_PER_MINUTE) begin : g_bad_spm
        $error("timing_generator: SECONDS_PER_MINUTE must be in 2..255");
    end

    // Pulses are registered one cycle early so they line up with the counters' terminal cycle.
    localparam logic [PRESC_W-1:0] PRESC_PENULT = PRESC_W'(CLOCKS_PER_SECOND - 2);
    localparam logic [SEC_W-1:0]   SEC_LAST     = SEC_W'(SECONDS_PER_MINUTE - 1);

    logic [PRESC_W-1:0] presc_count;
    logic [SEC_W-1:0]   sec_count;
    logic               presc_terminal;
    logic               sec_terminal;
    logic               second_next;
    logic               minute_next;

    mod_counter #(.MODULUS(CLOCKS_PER_SECOND)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (1'b1),
        .count    (presc_count),
        .terminal (presc_terminal)
    );

    mod_counter #(.MODULUS(SECONDS_PER_MINUTE)) u_seconds (
        .clk      (clk),
        .reset    (reset),
        .enable   (presc_terminal),
        .count    (sec_count),
        .terminal (sec_terminal)
    );

    assign second_next = (presc_count == PRESC_PENULT);
    assign minute_next = second_next && (sec_count == SEC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            one_second <= 1'b0;
            one_minute <= 1'b0;
        end else begin
            one_second <= second_next;
            one_minute <= minute_next;
        end
    end

    // The early-registered pulses must always agree with the counters' own terminal flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (one_second == presc_terminal);
            assert (one_minute == sec_terminal);
        end
    end

endmodule

// File: tb/tb_timing_generator.sv
// Directed bench: a 4/3 instance for pulse timing and reset abort, a default instance for long-run periods.
module tb_timing_generator;

    logic clk = 1'b0;
    logic rst_s;
    logic rst_d;
    logic prev_s_sec;
    logic prev_d_sec;
    int   checks   = 0;
    int   failures = 0;

    timing_generator_if small_if ();
    timing_generator_if def_if ();

    timing_generator #(
        .CLOCKS_PER_SECOND  (4),
        .SECONDS_PER_MINUTE (3)
    ) dut_small (
        .clk        (clk),
        .reset      (rst_s),
        .one_second (small_if.one_second),
        .one_minute (small_if.one_minute)
    );

    timing_generator dut_def (
        .clk        (clk),
        .reset      (rst_d),
        .one_second (def_if.one_second),
        .one_minute (def_if.one_minute)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, sample on the following falling edge, and check the pulse invariants.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check("s_minute_without_second", small_if.one_minute && !small_if.one_second, 1'b0);
        check("s_second_two_cycles", small_if.one_second && prev_s_sec, 1'b0);
        check("d_minute_without_second", def_if.one_minute && !def_if.one_second, 1'b0);
        check("d_second_two_cycles", def_if.one_second && prev_d_sec, 1'b0);
        prev_s_sec = small_if.one_second;
        prev_d_sec = def_if.one_second;
    endtask

    initial begin
        rst_s      = 1'b1;
        rst_d      = 1'b1;
        prev_s_sec = 1'b0;
        prev_d_sec = 1'b0;

        // Reset for two cycles; both instances must be quiet.
        tick();
        tick();
        check("s_reset_second", small_if.one_second, 1'b0);
        check("s_reset_minute", small_if.one_minute, 1'b0);
        check("d_reset_second", def_if.one_second, 1'b0);
        check("d_reset_minute", def_if.one_minute, 1'b0);

        // Seconds after edges 3,7,11,...; minutes after edges 11 and 23.
        rst_s = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            check("s_run_second", small_if.one_second, (k % 4) == 3);
            check("s_run_minute", small_if.one_minute, (k == 11) || (k == 23));
        end

        // Restart, then reset during the second pulse.
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("s_pre_abort_second", small_if.one_second, (k % 4) == 3);
            check("s_pre_abort_minute", small_if.one_minute, 1'b0);
        end
        check("s_second_pulse_seen", small_if.one_second, 1'b1);
        rst_s = 1'b1;
        tick();
        check("s_abort_second", small_if.one_second, 1'b0);
        check("s_abort_minute", small_if.one_minute, 1'b0);
        rst_s = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            check("s_post_abort_second", small_if.one_second, (j % 4) == 3);
            check("s_post_abort_minute", small_if.one_minute, j == 11);
        end

        // Long reset: everything stays low.
        rst_s = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            check("s_hold_second", small_if.one_second, 1'b0);
            check("s_hold_minute", small_if.one_minute, 1'b0);
            check("d_hold_second", def_if.one_second, 1'b0);
            check("d_hold_minute", def_if.one_minute, 1'b0);
        end

        // Default parameters: 256-cycle seconds, 15360-cycle minutes.
        rst_d = 1'b0;
        for (int k = 1; k <= 20000; k++) begin
            tick();
            check("d_run_second", def_if.one_second, (k % 256) == 255);
            check("d_run_minute", def_if.one_minute, (k % 15360) == 15359);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timing_generator.md
TIMING_GENERATOR -- requirements
Module: timing_generator

Interface
REQ-001 Parameter CLOCKS_PER_SECOND, default 256: clk cycles per one_second period; legal range 2..2^24.
REQ-002 Parameter SECONDS_PER_MINUTE, default 60: one_second pulses per one_minute pulse; legal range 2..255.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 Port one_second, output, 1 bit: one-clk-wide pulse, once per second.
REQ-006 Port one_minute, output, 1 bit: one-clk-wide pulse, once per minute.
REQ-007 Port order SHALL be clk, reset, one_second, one_minute, so positional instantiation works.

Function
REQ-008 A prescaler counter of width $clog2(CLOCKS_PER_SECOND) SHALL count 0..CLOCKS_PER_SECOND-1, incrementing every non-reset cycle and wrapping to 0.
REQ-009 one_second SHALL be registered and high for exactly the one cycle in which the prescaler holds CLOCKS_PER_SECOND-1; low otherwise.
REQ-010 Edge numbering: edge 1 is the first rising edge at which reset samples low. one_second SHALL rise after edge CLOCKS_PER_SECOND-1 and fall after edge CLOCKS_PER_SECOND.
REQ-011 one_second SHALL then repeat with period exactly CLOCKS_PER_SECOND cycles.
REQ-012 A seconds counter of width $clog2(SECONDS_PER_MINUTE) SHALL count 0..SECONDS_PER_MINUTE-1.
REQ-013 The seconds counter SHALL advance only in cycles where the prescaler wraps.
REQ-014 one_minute SHALL be high in exactly the cycle that holds the SECONDS_PER_MINUTE-th one_second pulse (seconds counter = SECONDS_PER_MINUTE-1 and prescaler = CLOCKS_PER_SECOND-1).
REQ-015 one_minute SHALL coincide with one_second in that cycle; it SHALL never be high without one_second.
REQ-016 one_minute SHALL repeat with period CLOCKS_PER_SECOND*SECONDS_PER_MINUTE cycles.
REQ-017 Both counters SHALL wrap to 0 simultaneously at the end of the one_minute cycle; no cycle is skipped or duplicated.
REQ-018 Outputs SHALL be glitch-free, driven directly from flops or a registered compare.
REQ-019 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-020 While reset is sampled high, the prescaler and seconds counter SHALL be 0, and one_second = 0, one_minute = 0 from the following edge.
REQ-021 Reset asserted mid-period, including during a pulse, SHALL abort the period. On release, timing restarts per REQ-010 with no partial or stale pulse.
REQ-022 Reset SHALL take priority over counting in every cycle.

Structure
REQ-023 A shared package timing_pkg SHALL hold the default constants DEFAULT_CLOCKS_PER_SECOND = 256 and DEFAULT_SECONDS_PER_MINUTE = 60.
REQ-024 One sub-module mod_counter SHALL be used (parameter MODULUS; ports clk, reset, enable, count, terminal). terminal = enable && count == MODULUS-1.
REQ-025 mod_counter SHALL be instantiated twice: as the prescaler (enable = 1) and as the seconds counter (enable = prescaler terminal).

Verification
REQ-026 CLOCKS_PER_SECOND = 4, SECONDS_PER_MINUTE = 3, reset for 2 cycles then released -> one_second high in the cycles after edges 3, 7, 11; one_minute high only after edge 11, next after edge 23.
REQ-027 Defaults, run 20000 cycles after reset -> one_second pulses 256 cycles apart, each 1 cycle wide; one_minute every 15360 cycles, always coincident with one_second.
REQ-028 CLOCKS_PER_SECOND = 4, SECONDS_PER_MINUTE = 3, reset asserted during the one_second cycle of the second pulse -> pulse drops on the next edge; after release, the next one_second comes CLOCKS_PER_SECOND-1 edges later and the minute count restarts.
REQ-029 Reset held high for 100 cycles -> both outputs stay 0 throughout.
REQ-030 Throughout all scenarios, assertion checks -> one_minute never high without one_second; neither output is ever high for 2 consecutive cycles.
REQ-031 CLOCKS_PER_SECOND = 1 -> elaboration fails.
